// File: rtl/uart_hash_loader_pkg.sv
// Shared definitions for the UART hash loader: command bytes, FSM encodings
// and the elaboration-time bit-period helper.
package uart_hash_loader_pkg;

  localparam logic [7:0] CMD_HASH = 8'h48;  // 'H'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

  typedef enum logic [1:0] {
    P_IDLE,
    P_HASH,
    P_RUN,
    P_ERR
  } parser_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT
  } rx_state_e;

  // Rounded clock cycles per UART bit.
  function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                             input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_hash_loader_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, 8N1 framing with
// one-cycle byte_valid / frame_err pulses.
module uart_rx
  import uart_hash_loader_pkg::*;
#(
  parameter int unsigned BIT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             expired;

  assign rx_s       = sync_q[1];
  assign expired    = (cnt_q == '0);
  assign byte_valid = valid_q;
  assign data       = shift_q;
  assign frame_err  = ferr_q;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values; blocking here would collapse the synchroniser to one stage.
      sync_q <= {sync_q[0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise paths that skip an assignment infer latches.
    state_d = state_q;
    cnt_d   = expired ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      R_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = R_START;
        end
      end
      R_START: begin
        // Re-check mid start bit so short glitches are rejected.
        if (expired) begin
          if (!rx_s) begin
            cnt_d   = CNT_FULL;
            bit_d   = '0;
            state_d = R_DATA;
          end else begin
            state_d = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (expired) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (expired) begin
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = R_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rx_s) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_hash_loader.sv
// Host-side front end of the NT hash cracker: parses 'H' + 16-byte hash
// loads and the 'G' start command from a UART stream.
module uart_hash_loader
  import uart_hash_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 62000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned MAX_HASHES = 128,
  parameter int unsigned HASH_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] new_hash_byte,
  output logic       store_hash_byte,
  output logic       go,
  output logic [7:0] hash_count,
  output logic       running,
  output logic       error
);

  localparam int unsigned BIT_CYC = bit_cycles(CLK_HZ, BAUD);
  localparam int unsigned IDX_W   = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HASH_BYTES - 1);
  localparam logic [7:0]       MAX_CNT  = 8'(MAX_HASHES);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ferr;

  parser_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          store_q, store_d;
  logic          go_q, go_d;
  logic [7:0]    count_q, count_d;
  logic          running_q, running_d;
  logic          error_q, error_d;

  uart_rx #(
    .BIT_CYC(BIT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(rx_valid),
    .data      (rx_data),
    .frame_err (rx_ferr)
  );

  assign new_hash_byte   = byte_q;
  assign store_hash_byte = store_q;
  assign go              = go_q;
  assign hash_count      = count_q;
  assign running         = running_q;
  assign error           = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= P_IDLE;
      idx_q     <= '0;
      byte_q    <= '0;
      store_q   <= 1'b0;
      go_q      <= 1'b0;
      count_q   <= '0;
      running_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      store_q   <= store_d;
      go_q      <= go_d;
      count_q   <= count_d;
      running_q <= running_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    store_d   = 1'b0;
    go_d      = 1'b0;
    count_d   = count_q;
    running_d = running_q;
    error_d   = error_q;

    if (rx_ferr) begin
      // A broken frame mid-hash would leave a partially written slot, so lock out.
      error_d = 1'b1;
      if (state_q == P_HASH) state_d = P_ERR;
    end else if (rx_valid) begin
      unique case (state_q)
        P_IDLE: begin
          if (rx_data == CMD_HASH) begin
            if (count_q < MAX_CNT) begin
              idx_d   = '0;
              state_d = P_HASH;
            end else begin
              error_d = 1'b1;
            end
          end else if (rx_data == CMD_GO) begin
            if (count_q != '0) begin
              go_d      = 1'b1;
              running_d = 1'b1;
              state_d   = P_RUN;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            error_d = 1'b1;
          end
        end
        P_HASH: begin
          byte_d  = rx_data;
          store_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = P_IDLE;
            if (count_q < MAX_CNT) count_d = count_q + 8'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        P_RUN, P_ERR: ;
        default: state_d = P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hash_loader.sv
// Scoreboard bench for uart_hash_loader at BIT_CYC=16 with two hash slots.
module tb_uart_hash_loader;

  localparam int unsigned BITC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] new_hash_byte;
  logic       store_hash_byte;
  logic       go;
  logic [7:0] hash_count;
  logic       running;
  logic       error;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  int         go_exp = 0;
  logic       go_prev = 1'b0;

  uart_hash_loader #(
    .CLK_HZ    (1600000),
    .BAUD      (100000),
    .MAX_HASHES(2),
    .HASH_BYTES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .new_hash_byte  (new_hash_byte),
    .store_hash_byte(store_hash_byte),
    .go             (go),
    .hash_count     (hash_count),
    .running        (running),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops expected hash bytes and go events whenever the DUT strobes.
  always @(negedge clk) begin
    if (rst) begin
      go_prev = 1'b0;
    end else begin
      if (store_hash_byte) begin
        if (exp_q.size() == 0) check("unexpected_store", {31'd0, store_hash_byte}, 32'd0);
        else check("store_byte", {24'd0, new_hash_byte}, {24'd0, exp_q.pop_front()});
      end
      if (go) begin
        if (go_exp == 0) check("unexpected_go", {31'd0, go}, 32'd0);
        else begin
          go_exp--;
          check("go_running", {31'd0, running}, 32'd1);
        end
      end
      if (go && go_prev) check("go_width", {31'd0, go_prev}, 32'd0);
      if (go && store_hash_byte) check("go_store_overlap", {31'd0, store_hash_byte}, 32'd0);
      go_prev = go;
    end
  end

  task automatic hold_rx(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold_rx(1'b0, BITC);
    for (int i = 0; i < 8; i++) hold_rx(b[i], BITC);
    hold_rx(stop_bit, BITC);
    hold_rx(1'b1, BITC);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_store);
    if (expect_store) exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic load_hash(input logic [7:0] base, input bit expect_store);
    send_byte(8'h48, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(base + 8'(i), expect_store);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    check({name, "_store_pending"}, exp_q.size(), 32'd0);
    check({name, "_go_pending"}, go_exp, 32'd0);
    exp_q.delete();
    go_exp = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_count", {24'd0, hash_count}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_store", {31'd0, store_hash_byte}, 32'd0);
    check("rst_go", {31'd0, go}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single hash load 0x00..0x0F.
    load_hash(8'h00, 1'b1);
    drain("t1");
    check("t1_count", {24'd0, hash_count}, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);

    // Two hashes, go, then ignored traffic in the run state.
    do_reset();
    load_hash(8'h10, 1'b1);
    load_hash(8'hA0, 1'b1);
    go_exp++;
    send_byte(8'h47, 1'b0);
    drain("t2go");
    check("t2_running", {31'd0, running}, 32'd1);
    load_hash(8'h30, 1'b0);
    drain("t2run");
    check("t2_count", {24'd0, hash_count}, 32'd2);
    check("t2_error", {31'd0, error}, 32'd0);

    // 'G' with nothing loaded is an error but the parser keeps accepting loads.
    do_reset();
    send_byte(8'h47, 1'b0);
    drain("t3g");
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_running", {31'd0, running}, 32'd0);
    load_hash(8'h50, 1'b1);
    drain("t3load");
    check("t3_count", {24'd0, hash_count}, 32'd1);

    // Framing error mid-hash locks the parser out.
    do_reset();
    send_byte(8'h48, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    send_frame(8'hAA, 1'b0);
    for (int i = 0; i < 11; i++) send_byte(8'hD0 + 8'(i), 1'b0);
    drain("t4");
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_count", {24'd0, hash_count}, 32'd0);

    // Full table rejects a further 'H'.
    do_reset();
    load_hash(8'h60, 1'b1);
    load_hash(8'h70, 1'b1);
    drain("t5load");
    check("t5_error_before", {31'd0, error}, 32'd0);
    send_byte(8'h48, 1'b0);
    drain("t5h");
    check("t5_error", {31'd0, error}, 32'd1);
    check("t5_count", {24'd0, hash_count}, 32'd2);

    // Short glitch is rejected; reset mid-byte discards the partial hash.
    do_reset();
    hold_rx(1'b0, 4);
    hold_rx(1'b1, 60);
    drain("t6glitch");
    check("t6_glitch_error", {31'd0, error}, 32'd0);
    load_hash(8'h80, 1'b1);
    send_byte(8'h48, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'h90 + 8'(i), 1'b1);
    drain("t6partial");
    check("t6_count_before", {24'd0, hash_count}, 32'd1);
    hold_rx(1'b0, BITC);
    for (int i = 0; i < 4; i++) hold_rx(1'b1, BITC);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_byte", {24'd0, new_hash_byte}, 32'd0);
    check("t6_rst_store", {31'd0, store_hash_byte}, 32'd0);
    check("t6_rst_go", {31'd0, go}, 32'd0);
    check("t6_rst_count", {24'd0, hash_count}, 32'd0);
    check("t6_rst_running", {31'd0, running}, 32'd0);
    check("t6_rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    load_hash(8'hE0, 1'b1);
    drain("t6reload");
    check("t6_count", {24'd0, hash_count}, 32'd1);
    check("t6_error", {31'd0, error}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
